// File: rtl/key_event_queue.sv
// Serialises one-cycle key pulses into an ordered FIFO of 2-bit key codes (fixed priority, lowest
// index first). Define KEY_REPEAT_EN to build per-key auto-repeat counters driven by k_level_i.
module key_event_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned CW            = 20,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] k_flag_i,
  input  logic [3:0] k_level_i,
  output logic       ev_valid_o,
  output logic [1:0] ev_code_o,
  input  logic       ev_ready_i,
  output logic       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [3:0]    pending_q, pending_d;
  logic [3:0]    new_ev, clr, rep_tick;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    push_idx;
  logic          full, empty, push, pop;

`ifdef KEY_REPEAT_EN
  logic [3:0][CW-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    rep_tick  = '0;
    rep_cnt_d = rep_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (k_level_i[i]) begin
        rep_cnt_d[i] = '0;
      end else if (rep_cnt_q[i] == CW'(REPEAT_DELAY - 1)) begin
        rep_tick[i]  = 1'b1;
        rep_cnt_d[i] = CW'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_cfg;
  assign rep_tick   = '0;
  assign unused_cfg = (^k_level_i) ^ (CW != 0) ^ (REPEAT_DELAY >= REPEAT_PERIOD);
`endif

  // Full/empty use registered pointers only, so a same-cycle pop never frees room for a push.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = (|pending_q) && !full;
  assign pop   = !empty && ev_ready_i;

  always_comb begin
    push_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) push_idx = 2'(i);
    end
  end

  // A new event on a bit being cleared this cycle is kept; otherwise it merges and is flagged.
  always_comb begin
    new_ev     = k_flag_i | rep_tick;
    clr        = push ? (4'b0001 << push_idx) : 4'b0000;
    pending_d  = (pending_q & ~clr) | new_ev;
    overflow_d = |(new_ev & pending_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_idx;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign ev_valid_o = !empty;
  assign ev_code_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: cycle vector table plus a scoreboard of delivered codes.
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] k_flag, k_level;
  logic       ev_ready, ev_valid, overflow;
  logic [1:0] ev_code;

  always #5 clk = ~clk;

  key_event_queue #(
    .DEPTH(4), .CW(20), .REPEAT_DELAY(1000), .REPEAT_PERIOD(200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .k_flag_i  (k_flag),
    .k_level_i (k_level),
    .ev_valid_o(ev_valid),
    .ev_code_o (ev_code),
    .ev_ready_i(ev_ready),
    .overflow_o(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_ovf    = 0;
  int n_code3  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overflow) n_ovf++;
      if (ev_valid && ev_ready) begin
        n_pops++;
        if (ev_code == 2'd3) n_code3++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got code %0d, required no event", ev_code);
        end else begin
          check("sb_code", {30'd0, ev_code}, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  typedef struct {
    logic [3:0] flag;
    logic       rdy;
    logic       v;
    logic [1:0] c;
    logic       o;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int base;
    int exp_n;

    tbl[0] = '{4'b0100, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2] = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[3] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[4] = '{4'b1001, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[5] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[6] = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[8] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[9] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};

    rst_n    = 1'b0;
    k_flag   = 4'd0;
    k_level  = 4'hF;
    ev_ready = 1'b0;
    #12;
    check("reset_valid", {31'd0, ev_valid}, 0);
    check("reset_code", {30'd0, ev_code}, 0);
    check("reset_overflow", {31'd0, overflow}, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Single press then simultaneous presses.
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    for (int i = 0; i < 10; i++) begin
      k_flag   = tbl[i].flag;
      ev_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), {31'd0, ev_valid}, {31'd0, tbl[i].v});
      if (tbl[i].v) check($sformatf("tbl%0d_code", i), {30'd0, ev_code}, {30'd0, tbl[i].c});
      check($sformatf("tbl%0d_overflow", i), {31'd0, overflow}, {31'd0, tbl[i].o});
      @(posedge clk);
      #1;
    end
    k_flag = 4'd0;

    // Fill the FIFO, park key 0 in pending, then coalesce a second key-0 press.
    ev_ready = 1'b0;
    base     = n_ovf;
    begin
      int keys[6] = '{0, 1, 2, 3, 0, 0};
      for (int i = 0; i < 6; i++) begin
        k_flag = 4'b0001 << keys[i];
        cyc(1);
      end
    end
    k_flag = 4'd0;
    cyc(4);
    check("fill_overflow_pulses", n_ovf - base, 1);
    @(negedge clk);
    check("fill_head_valid", {31'd0, ev_valid}, 1);
    check("fill_head_code", {30'd0, ev_code}, 0);
    @(posedge clk);
    #1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    base     = n_pops;
    ev_ready = 1'b1;
    cyc(12);
    check("fill_drain_count", n_pops - base, 5);
    check("fill_drain_empty", {31'd0, ev_valid}, 0);

    // Backpressure: head must hold for 10 cycles, then pop on first ready.
    ev_ready = 1'b0;
    k_flag   = 4'b0010;
    cyc(1);
    k_flag = 4'd0;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), {31'd0, ev_valid}, 1);
      check($sformatf("bp%0d_code", i), {30'd0, ev_code}, 1);
      @(posedge clk);
      #1;
    end
    exp_q.push_back(2'd1);
    ev_ready = 1'b1;
    cyc(1);
    ev_ready = 1'b0;
    @(negedge clk);
    check("bp_popped", {31'd0, ev_valid}, 0);
    @(posedge clk);
    #1;

    // Auto-repeat: key 3 held for 1400 cycles with a press pulse at the start.
`ifdef KEY_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    for (int i = 0; i < exp_n; i++) exp_q.push_back(2'd3);
    base     = n_code3;
    ev_ready = 1'b1;
    k_level  = 4'b0111;
    k_flag   = 4'b1000;
    cyc(1);
    k_flag = 4'd0;
    cyc(1399);
    k_level = 4'hF;
    cyc(10);
    check("repeat_events", n_code3 - base, exp_n);

    // Reset mid-operation discards queued events.
    ev_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      k_flag = 4'b0001 << k;
      cyc(1);
    end
    k_flag = 4'd0;
    cyc(3);
    @(negedge clk);
    check("pre_reset_valid", {31'd0, ev_valid}, 1);
    check("pre_reset_code", {30'd0, ev_code}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, ev_valid}, 0);
    check("mid_reset_code", {30'd0, ev_code}, 0);
    check("mid_reset_overflow", {31'd0, overflow}, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    base     = n_pops;
    cyc(10);
    check("post_reset_no_events", n_pops - base, 0);
    check("post_reset_valid", {31'd0, ev_valid}, 0);

    check("sb_all_delivered", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
